nios_hps_system_pll_rstseq: RTL and testbench

NIOS_HPS_SYSTEM_PLL_RSTSEQ -- requirements
Module: nios_hps_system_pll_rstseq

---
 rtl/nios_hps_system_pll_pkg.sv | 26 ++
 rtl/nios_hps_system_pll_sync2.sv | 23 ++
 rtl/nios_hps_system_pll_rstseq.sv | 172 +++++++++++++++++
 tb/tb_nios_hps_system_pll_rstseq.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_hps_system_pll_pkg.sv
// Shared definitions for the PLL reset sequencer: FSM state encoding,
// default parameter values and a small constant helper.
package nios_hps_system_pll_pkg;

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN,
    FAULT
  } state_t;

  localparam int DEF_RST_PULSE_CYC    = 16;
  localparam int DEF_LOCK_STABLE_CYC  = 1024;
  localparam int DEF_LOCK_TIMEOUT_CYC = 65536;
  localparam int DEF_N_DOM            = 3;
  localparam int DEF_STAGGER_CYC      = 8;
  localparam int DEF_MAX_RETRY        = 4;

  // Larger of two integers, used to size the shared phase counter
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/nios_hps_system_pll_sync2.sv
// Two-flop synchronizer bringing the asynchronous PLL lock flag into the
// reference clock domain. Both flops clear to 0 on reset.
module nios_hps_system_pll_sync2 (
  input  logic refclk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic meta;

  // Two-stage capture of an asynchronous level
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      dout <= 1'b0;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/nios_hps_system_pll_rstseq.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then
// releases the downstream domain resets one by one with a fixed stagger.
// Lock timeouts re-reset the PLL and are counted in retry_cnt.
// Optional feature macro: PLL_RSTSEQ_RETRY_LIMIT_EN -- when defined, reaching
// MAX_RETRY timeouts parks the sequencer in FAULT until soft_req or rst.
module nios_hps_system_pll_rstseq
  import nios_hps_system_pll_pkg::*;
#(
  parameter int RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
  parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
  parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
  parameter int N_DOM            = DEF_N_DOM,
  parameter int STAGGER_CYC      = DEF_STAGGER_CYC,
  parameter int MAX_RETRY        = DEF_MAX_RETRY
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             locked,
  input  logic             soft_req,
  output logic             pll_rst,
  output logic [N_DOM-1:0] dom_rst,
  output logic             ready,
  output logic [7:0]       retry_cnt,
  output logic             fault
);

  // One counter serves every state; it must hold the longest phase,
  // including the full staggered release span.
  localparam int CNT_MAX = max_int(max_int(RST_PULSE_CYC, LOCK_STABLE_CYC),
                                   max_int(LOCK_TIMEOUT_CYC, STAGGER_CYC * N_DOM));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);

`ifdef PLL_RSTSEQ_RETRY_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [7:0]       retry_inc;
  logic             limit_hit;
  logic             locked_s;
  logic             fault_reg;
  logic [N_DOM-1:0] dom_hit;

  nios_hps_system_pll_sync2 u_lock_sync (
    .refclk (refclk),
    .rst    (rst),
    .din    (locked),
    .dout   (locked_s)
  );

  assign cnt_inc   = cnt + CNT_W'(1);
  assign retry_inc = (retry_cnt == 8'hFF) ? retry_cnt : retry_cnt + 8'd1;
  // Without the retry-limit feature this is constant 0, so FAULT is unreachable
  assign limit_hit = LIMIT_EN && (int'(retry_inc) >= MAX_RETRY);
  assign fault     = fault_reg;

  // Domain gi is released when the RELEASE counter reaches STAGGER_CYC*(gi+1)
  generate
    for (genvar gi = 0; gi < N_DOM; gi++) begin : g_dom_hit
      assign dom_hit[gi] = (cnt_inc == CNT_W'(STAGGER_CYC * (gi + 1)));
    end
  endgenerate

  // Sequencer FSM with registered outputs; soft_req outranks every other event
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state     <= RESET_PLL;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      dom_rst   <= '1;
      ready     <= 1'b0;
      retry_cnt <= 8'd0;
      fault_reg <= 1'b0;
    end else if (soft_req) begin
      state     <= RESET_PLL;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      dom_rst   <= '1;
      ready     <= 1'b0;
      fault_reg <= 1'b0;
    end else begin
      case (state)
        RESET_PLL: begin
          if (cnt == PULSE_LAST) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            retry_cnt <= retry_inc;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            if (limit_hit) begin
              state     <= FAULT;
              fault_reg <= 1'b1;
            end else begin
              state <= RESET_PLL;
            end
          end else begin
            cnt <= cnt_inc;
          end
        end
        STABLE: begin
          if (!locked_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state <= RELEASE;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        RELEASE: begin
          if (!locked_s) begin
            state   <= RESET_PLL;
            cnt     <= '0;
            pll_rst <= 1'b1;
            dom_rst <= '1;
          end else begin
            cnt     <= cnt_inc;
            dom_rst <= dom_rst & ~dom_hit;
            if (dom_hit[N_DOM-1]) begin
              state <= RUN;
              cnt   <= '0;
              ready <= 1'b1;
            end
          end
        end
        RUN: begin
          if (!locked_s) begin
            state   <= RESET_PLL;
            cnt     <= '0;
            pll_rst <= 1'b1;
            dom_rst <= '1;
            ready   <= 1'b0;
          end
        end
        FAULT: begin
          // Parked with everything held in reset; only soft_req or rst leave
          cnt     <= '0;
          pll_rst <= 1'b1;
          dom_rst <= '1;
          ready   <= 1'b0;
        end
        default: begin
          state   <= RESET_PLL;
          cnt     <= '0;
          pll_rst <= 1'b1;
          dom_rst <= '1;
          ready   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nios_hps_system_pll_rstseq.sv
// Directed bench for the PLL reset sequencer using the short verification
// parameter set. Each task drives one scenario and checks every cycle
// against hand-derived edge numbers.
module tb_nios_hps_system_pll_rstseq;

  localparam int RP = 4;
  localparam int LS = 8;
  localparam int LT = 32;
  localparam int ND = 3;
  localparam int SG = 2;
  localparam int MR = 2;

`ifdef PLL_RSTSEQ_RETRY_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  logic          refclk = 1'b0;
  logic          rst;
  logic          locked;
  logic          soft_req;
  logic          pll_rst;
  logic [ND-1:0] dom_rst;
  logic          ready;
  logic [7:0]    retry_cnt;
  logic          fault;

  int checks   = 0;
  int failures = 0;
  // retry count left after the timeout scenario (limit stops it at MR)
  int retry_after;

  always #5 refclk = ~refclk;

  nios_hps_system_pll_rstseq #(
    .RST_PULSE_CYC    (RP),
    .LOCK_STABLE_CYC  (LS),
    .LOCK_TIMEOUT_CYC (LT),
    .N_DOM            (ND),
    .STAGGER_CYC      (SG),
    .MAX_RETRY        (MR)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .locked    (locked),
    .soft_req  (soft_req),
    .pll_rst   (pll_rst),
    .dom_rst   (dom_rst),
    .ready     (ready),
    .retry_cnt (retry_cnt),
    .fault     (fault)
  );

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; locked = 1'b0; soft_req = 1'b0;
    tick(); tick(); tick();
    checks++;
    if ({pll_rst, dom_rst, ready, fault, retry_cnt} !== {1'b1, 3'b111, 1'b0, 1'b0, 8'd0}) begin
      failures++;
      $display("FAIL reset_state: got pll=%b dom=%b ready=%b fault=%b retry=%0d want pll=1 dom=111 ready=0 fault=0 retry=0",
               pll_rst, dom_rst, ready, fault, retry_cnt);
    end
    $display("reset: pll=%b dom=%b ready=%b", pll_rst, dom_rst, ready);
  endtask

  // rst released at edge 0, lock raised after edge 10: STABLE from 13,
  // RELEASE at 21, domains free at 23/25/27
  task automatic test_startup();
    logic [4:0] exp;
    rst = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      tick();
      exp = {n < 4, n < 27, n < 25, n < 23, n >= 27};
      checks++;
      if ({pll_rst, dom_rst, ready} !== exp) begin
        failures++;
        $display("FAIL startup cyc %0d: got %b want %b", n, {pll_rst, dom_rst, ready}, exp);
      end
      if (n == 10) locked = 1'b1;
    end
    $display("startup: ready=%b retry=%0d", ready, retry_cnt);
  endtask

  // lock lost in RUN after edge 0: restart at edge 3, relock after 3,
  // pulse ends 7, STABLE 8, RELEASE 16, domains 18/20/22
  task automatic test_lock_loss();
    logic [4:0] exp;
    locked = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      exp = (k < 3) ? 5'b0_000_1 : {k < 7, k < 22, k < 20, k < 18, k >= 22};
      checks++;
      if ({pll_rst, dom_rst, ready} !== exp) begin
        failures++;
        $display("FAIL lock_loss cyc %0d: got %b want %b", k, {pll_rst, dom_rst, ready}, exp);
      end
      if (k == 3) locked = 1'b1;
    end
    checks++;
    if (retry_cnt !== 8'd0) begin
      failures++;
      $display("FAIL lock_loss_retry: got %0d want 0", retry_cnt);
    end
    $display("lock_loss: ready=%b retry=%0d", ready, retry_cnt);
  endtask

  // rst asserted mid-cycle from RUN must take effect without a clock edge
  task automatic test_async_reset();
    rst = 1'b1;
    #2;
    checks++;
    if ({pll_rst, dom_rst, ready, retry_cnt} !== {1'b1, 3'b111, 1'b0, 8'd0}) begin
      failures++;
      $display("FAIL async_reset: got pll=%b dom=%b ready=%b retry=%0d want 1 111 0 0",
               pll_rst, dom_rst, ready, retry_cnt);
    end
    $display("async_reset: pll=%b dom=%b ready=%b", pll_rst, dom_rst, ready);
  endtask

  // lock high through reset; 1-cycle glitch after edge 7 is seen at edge 10,
  // STABLE restarts at 11, RELEASE 19, domains 21/23/25
  task automatic test_glitch();
    logic [4:0] exp;
    locked = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int n = 1; n <= 28; n++) begin
      tick();
      exp = {n < 4, n < 25, n < 23, n < 21, n >= 25};
      checks++;
      if ({pll_rst, dom_rst, ready} !== exp) begin
        failures++;
        $display("FAIL glitch cyc %0d: got %b want %b", n, {pll_rst, dom_rst, ready}, exp);
      end
      if (n == 7) locked = 1'b0;
      if (n == 8) locked = 1'b1;
    end
    checks++;
    if (retry_cnt !== 8'd0) begin
      failures++;
      $display("FAIL glitch_retry: got %0d want 0", retry_cnt);
    end
    $display("glitch: ready=%b retry=%0d", ready, retry_cnt);
  endtask

  // no lock: 36-cycle retry period (4 pulse + 32 wait)
  task automatic test_timeout();
    logic [14:0] exp;
    logic        e_pll;
    logic        e_fault;
    int          e_retry;
    rst = 1'b1; locked = 1'b0;
    tick(); tick();
    rst = 1'b0;
    for (int n = 1; n <= 110; n++) begin
      tick();
      if (LIMIT && n >= 72) begin
        e_pll = 1'b1; e_fault = 1'b1; e_retry = MR;
      end else begin
        e_pll = ((n % 36) < 4); e_fault = 1'b0; e_retry = n / 36;
      end
      exp = {e_pll, 3'b111, 1'b0, e_fault, 8'(e_retry)};
      checks++;
      if ({pll_rst, dom_rst, ready, fault, retry_cnt} !== exp) begin
        failures++;
        $display("FAIL timeout cyc %0d: got pll=%b dom=%b ready=%b fault=%b retry=%0d want %b",
                 n, pll_rst, dom_rst, ready, fault, retry_cnt, exp);
      end
    end
    retry_after = LIMIT ? MR : 3;
    checks++;
    if (!LIMIT && fault !== 1'b0) begin
      failures++;
      $display("FAIL timeout_nofault: got fault=%b want 0", fault);
    end
    $display("timeout: retry=%0d fault=%b pll=%b", retry_cnt, fault, pll_rst);
  endtask

  // soft_req (from FAULT or mid-pulse) with lock restored: pulse restarts,
  // WAIT_LOCK 5, STABLE 6, RELEASE 14, domains 16/18/20
  task automatic test_soft_fault();
    logic [4:0] exp;
    locked = 1'b1; soft_req = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      tick();
      if (k == 1) soft_req = 1'b0;
      exp = {k < 5, k < 20, k < 18, k < 16, k >= 20};
      checks++;
      if ({pll_rst, dom_rst, ready, fault} !== {exp, 1'b0}) begin
        failures++;
        $display("FAIL soft_fault cyc %0d: got %b fault=%b want %b fault=0",
                 k, {pll_rst, dom_rst, ready}, fault, exp);
      end
    end
    checks++;
    if (retry_cnt !== 8'(retry_after)) begin
      failures++;
      $display("FAIL soft_fault_retry: got %0d want %0d", retry_cnt, retry_after);
    end
    $display("soft_fault: ready=%b fault=%b retry=%0d", ready, fault, retry_cnt);
  endtask

  // soft_req lands on the same edge (3) as the synchronized lock loss
  task automatic test_coincident();
    logic [4:0] exp;
    locked = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      exp = (k < 3) ? 5'b0_000_1 : {k < 7, k < 22, k < 20, k < 18, k >= 22};
      checks++;
      if ({pll_rst, dom_rst, ready} !== exp) begin
        failures++;
        $display("FAIL coincident cyc %0d: got %b want %b", k, {pll_rst, dom_rst, ready}, exp);
      end
      if (k == 2) soft_req = 1'b1;
      if (k == 3) begin
        soft_req = 1'b0;
        locked   = 1'b1;
      end
    end
    checks++;
    if (retry_cnt !== 8'(retry_after)) begin
      failures++;
      $display("FAIL coincident_retry: got %0d want %0d", retry_cnt, retry_after);
    end
    $display("coincident: ready=%b retry=%0d", ready, retry_cnt);
  endtask

  initial begin
    test_reset();
    test_startup();
    test_lock_loss();
    test_async_reset();
    test_glitch();
    test_timeout();
    test_soft_fault();
    test_coincident();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
